// File: rtl/chip8_burst_mem_ctrl_if.sv
// Request/done handshake between the Chip-8 CPU core and the burst memory controller.
// The CPU side uses the master modport and the controller uses the slave modport.
interface chip8_burst_mem_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int BURST  = 16,
   parameter int CNT_W  = $clog2(BURST)
);
   logic                 start;
   logic [1:0]           op;
   logic [CNT_W-1:0]     count;
   logic [ADDR_W-1:0]    address;
   logic [ADDR_W-1:0]    pc;
   logic [8*BURST-1:0]   write_buffer;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [8*BURST-1:0]   read_buffer;
   logic [15:0]          opcode;

   modport master (
      output start, op, count, address, pc, write_buffer,
      input  busy, done, err, read_buffer, opcode
   );

   modport slave (
      input  start, op, count, address, pc, write_buffer,
      output busy, done, err, read_buffer, opcode
   );
endinterface

// File: rtl/chip8_burst_mem_ctrl.sv
// Chip-8 main RAM owner: sequences opcode fetches and 1..BURST byte burst reads/writes
// through a single-port RAM with registered read, behind a start/done handshake.
module chip8_burst_mem_ctrl #(
   parameter int    ADDR_W    = 12,
   parameter int    BURST     = 16,
   parameter int    CNT_W     = $clog2(BURST),
   parameter string INIT_FILE = ""
) (
   input  logic                   clk,
   input  logic                   rst_n,
   chip8_burst_mem_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, FETCH, READ, WRITE, FINISH} state_t;

   state_t              state_reg;
   logic [CNT_W:0]      k_reg;
   logic [CNT_W:0]      last_reg;
   logic [ADDR_W-1:0]   base_reg;
   logic                busy_reg;
   logic                done_reg;
   logic                err_reg;
   logic [8*BURST-1:0]  read_buffer_reg;
   logic [15:0]         opcode_reg;

   logic [7:0]          mem [2**ADDR_W];
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_we;
   logic [7:0]          ram_wdata;
   logic [7:0]          ram_rdata;
   logic [CNT_W-1:0]    k_byte;
   logic [CNT_W-1:0]    cap_idx;

   // Byte k is addressed in cycle k; its data returns one cycle later and is captured as byte k-1.
   assign k_byte    = k_reg[CNT_W-1:0];
   assign cap_idx   = k_byte - 1'b1;
   assign ram_addr  = base_reg + ADDR_W'(k_reg);
   assign ram_we    = (state_reg == WRITE);
   assign ram_wdata = bus.write_buffer[{k_byte, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         k_reg           <= '0;
         last_reg        <= '0;
         base_reg        <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
         read_buffer_reg <= '0;
         opcode_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE, FINISH: begin
               // FINISH also accepts, so a new start may coincide with the done pulse.
               state_reg <= IDLE;
               k_reg     <= '0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               err_reg   <= 1'b0;
               if (bus.start) begin
                  case (bus.op)
                     2'b00: begin
                        state_reg <= FETCH;
                        base_reg  <= bus.pc;
                        last_reg  <= (CNT_W+1)'(1);
                        busy_reg  <= 1'b1;
                     end
                     2'b01: begin
                        state_reg <= READ;
                        base_reg  <= bus.address;
                        last_reg  <= {1'b0, bus.count};
                        busy_reg  <= 1'b1;
                     end
                     2'b10: begin
                        state_reg <= WRITE;
                        base_reg  <= bus.address;
                        last_reg  <= {1'b0, bus.count};
                        busy_reg  <= 1'b1;
                     end
                     default: begin
                        state_reg <= FINISH;
                        done_reg  <= 1'b1;
                        err_reg   <= 1'b1;
                     end
                  endcase
               end
            end
            FETCH, READ: begin
               if (k_reg != '0) begin
                  if (state_reg == FETCH) begin
                     if (k_reg == (CNT_W+1)'(1)) opcode_reg[15:8] <= ram_rdata;
                     else                        opcode_reg[7:0]  <= ram_rdata;
                  end else begin
                     read_buffer_reg[{cap_idx, 3'b000} +: 8] <= ram_rdata;
                  end
               end
               if (k_reg == last_reg + 1'b1) begin
                  state_reg <= FINISH;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  k_reg <= k_reg + 1'b1;
               end
            end
            WRITE: begin
               if (k_reg == last_reg) begin
                  state_reg <= FINISH;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  k_reg <= k_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.err         = err_reg;
   assign bus.read_buffer = read_buffer_reg;
   assign bus.opcode      = opcode_reg;
endmodule

// File: tb/tb_chip8_burst_mem_ctrl.sv
// Directed bench for chip8_burst_mem_ctrl: stimulus pushes expected completions into a
// scoreboard queue, and a monitor pops and compares them on every done pulse.
module tb_chip8_burst_mem_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chip8_burst_mem_ctrl_if #(.ADDR_W(12), .BURST(16)) bus ();

   chip8_burst_mem_ctrl #(.ADDR_W(12), .BURST(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string        name;
      logic [1:0]   op;
      int           lat;
      int           bsy;
      logic         err;
      logic [15:0]  opc;
      logic [127:0] rb;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   passed  = 0;
   int   cyc     = 0;
   int   acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, want);
   endtask

   // Monitor: latency counts posedges from the accept edge to the cycle where done is seen.
   initial begin : monitor
      int   bcnt;
      logic prev_done;
      exp_t e;
      bcnt = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bcnt = 0;
            prev_done = 1'b0;
         end else begin
            if (prev_done) check("done_single_cycle", 128'(bus.done), 128'(0));
            if (bus.busy) bcnt++;
            if (bus.done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 128'(bus.done), 128'(0));
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_latency"}, 128'(cyc - acc_cyc), 128'(e.lat));
                  check({e.name, "_busy_cycles"}, 128'(bcnt), 128'(e.bsy));
                  check({e.name, "_err"}, 128'(bus.err), 128'(e.err));
                  if (e.op == 2'b00) check({e.name, "_opcode"}, 128'(bus.opcode), 128'(e.opc));
                  if (e.op == 2'b01) check({e.name, "_read_buffer"}, bus.read_buffer, e.rb);
               end
               $display("txn %s done at cycle %0d err=%0b opcode=%h rb=%h",
                        (sb.size() == 0 && e.name.len() == 0) ? "?" : e.name,
                        cyc, bus.err, bus.opcode, bus.read_buffer);
               bcnt = 0;
            end
            prev_done = bus.done;
         end
      end
   end

   task automatic do_op(input string nm, input logic [1:0] op, input logic [3:0] cnt,
                        input logic [11:0] adr, input logic [11:0] pcv, input logic [127:0] wb,
                        input int lat, input int bsy, input logic err,
                        input logic [15:0] opc, input logic [127:0] rb, input bit glitch);
      exp_t e;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.op           = op;
      bus.count        = cnt;
      bus.address      = adr;
      bus.pc           = pcv;
      bus.write_buffer = wb;
      acc_cyc          = cyc;
      e.name = nm; e.op = op; e.lat = lat; e.bsy = bsy; e.err = err; e.opc = opc; e.rb = rb;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      if (glitch) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.op    = 2'b11;
         @(negedge clk);
         bus.start = 1'b0;
      end
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL %s_timeout: done not seen, %0d completions still pending (required 0)",
                  nm, sb.size());
         sb.delete();
      end
   endtask

   localparam logic [127:0] PAT_K11  = 128'hFFEEDDCCBBAA99887766554433221100;
   localparam logic [127:0] PAT_A0   = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
   localparam logic [127:0] ALL_55   = {16{8'h55}};
   localparam logic [127:0] RB_MIX   = 128'hFFEEDDCCBBAA99887766554444332211;
   localparam logic [127:0] RB_ABORT = 128'h5555555555555555555555A4A3A2A1A0;

   initial begin
      bus.start = 1'b0; bus.op = 2'b00; bus.count = '0;
      bus.address = '0; bus.pc = '0; bus.write_buffer = '0;
      repeat (2) @(negedge clk);
      check("reset_busy",        128'(bus.busy),   128'(0));
      check("reset_done",        128'(bus.done),   128'(0));
      check("reset_err",         128'(bus.err),    128'(0));
      check("reset_read_buffer", bus.read_buffer,  128'(0));
      check("reset_opcode",      128'(bus.opcode), 128'(0));
      rst_n = 1'b1;

      //    name          op     cnt  addr     pc       wb                  lat bsy err opc       rb
      do_op("write200",   2'b10, 3,  12'h200, 12'h000, 128'h44332211,     5,  4, 0, 16'h0000, 0, 0);
      do_op("fetch200",   2'b00, 0,  12'h000, 12'h200, 128'h0,            4,  3, 0, 16'h1122, 0, 0);
      do_op("read200",    2'b01, 3,  12'h200, 12'h000, 128'h0,            6,  5, 0, 16'h0000, 128'h44332211, 0);
      do_op("write_wrap", 2'b10, 1,  12'hFFF, 12'h000, 128'hCDAB,         3,  2, 0, 16'h0000, 0, 0);
      do_op("fetch_wrap", 2'b00, 0,  12'h000, 12'hFFF, 128'h0,            4,  3, 0, 16'hABCD, 0, 0);
      do_op("read000",    2'b01, 0,  12'h000, 12'h000, 128'h0,            3,  2, 0, 16'h0000, 128'h443322CD, 0);
      do_op("write300",   2'b10, 15, 12'h300, 12'h000, PAT_K11,           17, 16, 0, 16'h0000, 0, 0);
      do_op("read300",    2'b01, 15, 12'h300, 12'h000, 128'h0,            18, 17, 0, 16'h0000, PAT_K11, 0);
      do_op("read_glitch",2'b01, 3,  12'h200, 12'h000, 128'h0,            6,  5, 0, 16'h0000, RB_MIX, 1);
      do_op("reserved",   2'b11, 3,  12'h200, 12'h000, 128'hDEADBEEF,     1,  0, 1, 16'h0000, 0, 0);
      do_op("read_after", 2'b01, 3,  12'h200, 12'h000, 128'h0,            6,  5, 0, 16'h0000, RB_MIX, 0);
      do_op("write400",   2'b10, 15, 12'h400, 12'h000, ALL_55,            17, 16, 0, 16'h0000, 0, 0);

      // Abort a 16-byte write after bytes 0..4 have been committed.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.count = 4'd15;
      bus.address = 12'h400; bus.write_buffer = PAT_A0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy",        128'(bus.busy),   128'(0));
      check("abort_done",        128'(bus.done),   128'(0));
      check("abort_err",         128'(bus.err),    128'(0));
      check("abort_read_buffer", bus.read_buffer,  128'(0));
      check("abort_opcode",      128'(bus.opcode), 128'(0));
      $display("txn abort: reset asserted mid-write at cycle %0d", cyc);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check("abort_idle_busy", 128'(bus.busy), 128'(0));

      do_op("read400",    2'b01, 15, 12'h400, 12'h000, 128'h0,            18, 17, 0, 16'h0000, RB_ABORT, 0);
      do_op("fetch400",   2'b00, 0,  12'h000, 12'h400, 128'h0,            4,  3, 0, 16'hA0A1, 0, 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
